// File: rtl/control_unit_gen2.sv
// rtl/control_unit_gen2.sv - gen2 multi-cycle control unit; optional single-step via CU_SINGLE_STEP_EN
module control_unit_gen2 #(
  parameter int OPW         = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           Reset,
`ifdef CU_SINGLE_STEP_EN
  input  logic           Step,
`endif
  input  logic [OPW-1:0] IR,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic           Aneg,
  input  logic           Enter,
  input  logic           MemReady,
  output logic           IRload,
  output logic           PCload,
  output logic           JMPmux,
  output logic           Meminst,
  output logic           MemReq,
  output logic           MemWr,
  output logic [1:0]     Asel,
  output logic [2:0]     AluOp,
  output logic           Aload,
  output logic           Oload,
  output logic           Halt,
  output logic           Fault,
  output logic [4:0]     state
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [4:0] {
    S_START  = 5'd0,  S_FETCH  = 5'd1,  S_DECODE = 5'd2,  S_LOAD   = 5'd3,
    S_STORE  = 5'd4,  S_ADD    = 5'd5,  S_SUB    = 5'd6,  S_INPUT  = 5'd7,
    S_JZ     = 5'd8,  S_JPOS   = 5'd9,  S_HALT   = 5'd10, S_AND    = 5'd11,
    S_OR     = 5'd12, S_NOT    = 5'd13, S_JMP    = 5'd14, S_OUTPUT = 5'd15,
    S_JNEG   = 5'd16, S_FAULT  = 5'd31
  } state_e;

  state_e        state_q, state_d, dec_state;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          enter_hi_q, enter_hi_d;
  logic          step_go;
  logic          mem_timeout;
  logic [3:0]    op;

  assign op    = 4'(IR);
  assign state = state_q;

`ifdef CU_SINGLE_STEP_EN
  logic step_q;
  assign step_go = Step && !step_q;

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) step_q <= 1'b0;
    else        step_q <= Step;
  end
`else
  assign step_go = 1'b1;
`endif

  // cnt_q holds the number of MemReady-low cycles already spent in this access
  assign mem_timeout = (MEM_TIMEOUT != 0) && ((int'(cnt_q) + 1) >= MEM_TIMEOUT);

  always_comb begin
    dec_state = S_FAULT;
    case (op)
      4'd0: dec_state = S_LOAD;
      4'd1: dec_state = S_STORE;
      4'd2: dec_state = S_ADD;
      4'd3: dec_state = S_SUB;
      4'd4: dec_state = S_INPUT;
      4'd5: dec_state = S_JZ;
      4'd6: dec_state = S_JPOS;
      4'd7: dec_state = S_HALT;
      default: begin
        if (OPW > 3) begin
          case (op)
            4'd8:    dec_state = S_AND;
            4'd9:    dec_state = S_OR;
            4'd10:   dec_state = S_NOT;
            4'd11:   dec_state = S_JMP;
            4'd12:   dec_state = S_OUTPUT;
            4'd13:   dec_state = S_JNEG;
            4'd14:   dec_state = S_START;
            default: dec_state = S_FAULT;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    enter_hi_d = enter_hi_q;
    case (state_q)
      S_START: state_d = step_go ? S_FETCH : S_START;
      S_FETCH, S_LOAD, S_STORE, S_ADD, S_SUB, S_AND, S_OR: begin
        if (MemReady)         state_d = (state_q == S_FETCH) ? S_DECODE : S_START;
        else if (mem_timeout) state_d = S_FAULT;
        else                  cnt_d   = cnt_q + CW'(1);
      end
      S_DECODE: begin
        state_d    = dec_state;
        // Treat Enter as already high on entry so a held strobe cannot complete INPUT
        enter_hi_d = 1'b1;
      end
      S_INPUT: begin
        enter_hi_d = Enter;
        if (Enter && !enter_hi_q) state_d = S_START;
      end
      S_HALT, S_FAULT: state_d = state_q;
      default: state_d = S_START;
    endcase
  end

  always_ff @(negedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_START;
      cnt_q      <= '0;
      enter_hi_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enter_hi_q <= enter_hi_d;
    end
  end

  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemReq  = 1'b0;
    MemWr   = 1'b0;
    Asel    = 2'b00;
    AluOp   = 3'b000;
    Aload   = 1'b0;
    Oload   = 1'b0;
    Halt    = 1'b0;
    Fault   = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq = 1'b1;
        IRload = MemReady;
        PCload = MemReady;
      end
      S_DECODE: Meminst = 1'b1;
      S_LOAD: begin
        Meminst = 1'b1; MemReq = 1'b1; Asel = 2'b10; Aload = MemReady;
      end
      S_ADD: begin
        Meminst = 1'b1; MemReq = 1'b1; AluOp = 3'b001; Aload = MemReady;
      end
      S_SUB: begin
        Meminst = 1'b1; MemReq = 1'b1; AluOp = 3'b010; Aload = MemReady;
      end
      S_AND: begin
        Meminst = 1'b1; MemReq = 1'b1; AluOp = 3'b011; Aload = MemReady;
      end
      S_OR: begin
        Meminst = 1'b1; MemReq = 1'b1; AluOp = 3'b100; Aload = MemReady;
      end
      S_STORE: begin
        Meminst = 1'b1; MemReq = 1'b1; MemWr = 1'b1;
      end
      S_NOT: begin
        AluOp = 3'b101; Aload = 1'b1;
      end
      S_INPUT: begin
        Asel  = 2'b01;
        Aload = Enter && !enter_hi_q;
      end
      S_OUTPUT: Oload = 1'b1;
      S_JMP: begin
        JMPmux = 1'b1; PCload = 1'b1;
      end
      S_JZ: begin
        JMPmux = 1'b1; PCload = Aeq0;
      end
      S_JPOS: begin
        JMPmux = 1'b1; PCload = Apos;
      end
      S_JNEG: begin
        JMPmux = 1'b1; PCload = Aneg;
      end
      S_HALT: Halt = 1'b1;
      S_FAULT: begin
        Fault = 1'b1; Halt = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
